// File: rtl/ball_mover_if.sv
// Ball motion interface: cue/collision/pocket controls in, position/velocity/state out.
interface ball_mover_if;
  logic               startOfFrame;
  logic               hitValid;
  logic signed [10:0] hitVelX, hitVelY;
  logic               collisionOccurred;
  logic signed [10:0] collisionVelX, collisionVelY;
  logic               pocketed;
  logic signed [10:0] topLeftX, topLeftY;
  logic signed [10:0] velX, velY;
  logic               moving;
  logic               inPocket;

  modport master (
    output startOfFrame, hitValid, hitVelX, hitVelY,
           collisionOccurred, collisionVelX, collisionVelY, pocketed,
    input  topLeftX, topLeftY, velX, velY, moving, inPocket
  );

  modport slave (
    input  startOfFrame, hitValid, hitVelX, hitVelY,
           collisionOccurred, collisionVelX, collisionVelY, pocketed,
    output topLeftX, topLeftY, velX, velY, moving, inPocket
  );
endinterface

// File: rtl/ball_mover.sv
// Per-ball fixed-point motion engine: frame-stepped position, cue hits, collision override, pocketing.
// Optional per-frame friction is enabled by defining BALL_MOVER_FRICTION_EN.
module ball_mover #(
  parameter logic signed [10:0] INIT_X          = 11'sd100,
  parameter logic signed [10:0] INIT_Y          = 11'sd200,
  parameter int                 FRAC            = 4,
  parameter logic signed [10:0] MAX_SPEED       = 11'sd255,
  parameter int                 FRICTION_PERIOD = 4
) (
  input  logic        clk,
  input  logic        reset,
  ball_mover_if.slave bm
);
  localparam int W = 11 + FRAC;

  if (FRICTION_PERIOD < 1) begin : g_bad_period
    $error("FRICTION_PERIOD must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, MOVING, POCKETED} state_t;

  state_t             state;
  logic signed [W-1:0] pos_x, pos_y, nxt_x, nxt_y;
  logic signed [10:0] vel_x, vel_y, lat_x, lat_y;
  logic signed [10:0] cvx, cvy, fvx, fvy;
  logic               lat_vld, moving_q, pocket_q;

`ifdef BALL_MOVER_FRICTION_EN
  localparam int CW = (FRICTION_PERIOD > 1) ? $clog2(FRICTION_PERIOD) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FRICTION_PERIOD - 1);
  logic [CW-1:0] fric_cnt;
  logic          fric_wrap;
  assign fric_wrap = (fric_cnt == CNT_LAST);
`endif

  function automatic logic signed [10:0] clamp(input logic signed [10:0] v);
    if (v > MAX_SPEED)  return MAX_SPEED;
    if (v < -MAX_SPEED) return -MAX_SPEED;
    return v;
  endfunction

  function automatic logic signed [10:0] toward_zero(input logic signed [10:0] v);
    if (v > 11'sd0) return v - 11'sd1;
    if (v < 11'sd0) return v + 11'sd1;
    return v;
  endfunction

  // Frame update chain: collision override, then friction, then advance with the result.
  always_comb begin
    cvx = lat_vld ? clamp(lat_x) : vel_x;
    cvy = lat_vld ? clamp(lat_y) : vel_y;
    fvx = cvx;
    fvy = cvy;
`ifdef BALL_MOVER_FRICTION_EN
    if (fric_wrap) begin
      fvx = toward_zero(cvx);
      fvy = toward_zero(cvy);
    end
`endif
    nxt_x = pos_x + {{FRAC{fvx[10]}}, fvx};
    nxt_y = pos_y + {{FRAC{fvy[10]}}, fvy};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pos_x    <= {INIT_X, {FRAC{1'b0}}};
      pos_y    <= {INIT_Y, {FRAC{1'b0}}};
      vel_x    <= '0;
      vel_y    <= '0;
      lat_vld  <= 1'b0;
      lat_x    <= '0;
      lat_y    <= '0;
      moving_q <= 1'b0;
      pocket_q <= 1'b0;
`ifdef BALL_MOVER_FRICTION_EN
      fric_cnt <= '0;
`endif
    end else if (state != POCKETED && bm.pocketed) begin
      state    <= POCKETED;
      vel_x    <= '0;
      vel_y    <= '0;
      lat_vld  <= 1'b0;
      moving_q <= 1'b0;
      pocket_q <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bm.hitValid && (bm.hitVelX != '0 || bm.hitVelY != '0)) begin
            vel_x    <= clamp(bm.hitVelX);
            vel_y    <= clamp(bm.hitVelY);
            state    <= MOVING;
            moving_q <= 1'b1;
`ifdef BALL_MOVER_FRICTION_EN
            fric_cnt <= '0;
`endif
          end
        end
        MOVING: begin
          if (bm.startOfFrame) begin
            vel_x <= fvx;
            vel_y <= fvy;
            pos_x <= nxt_x;
            pos_y <= nxt_y;
`ifdef BALL_MOVER_FRICTION_EN
            fric_cnt <= fric_wrap ? '0 : fric_cnt + 1'b1;
`endif
            if (fvx == '0 && fvy == '0) begin
              state    <= IDLE;
              moving_q <= 1'b0;
              lat_vld  <= 1'b0;
            end else begin
              // A collision on the frame strobe itself belongs to the next frame.
              lat_vld <= bm.collisionOccurred;
              if (bm.collisionOccurred) begin
                lat_x <= bm.collisionVelX;
                lat_y <= bm.collisionVelY;
              end
            end
          end else if (bm.collisionOccurred && !lat_vld) begin
            lat_vld <= 1'b1;
            lat_x   <= bm.collisionVelX;
            lat_y   <= bm.collisionVelY;
          end
        end
        default: ;
      endcase
    end
  end

  assign bm.topLeftX = pos_x[W-1:FRAC];
  assign bm.topLeftY = pos_y[W-1:FRAC];
  assign bm.velX     = vel_x;
  assign bm.velY     = vel_y;
  assign bm.moving   = moving_q;
  assign bm.inPocket = pocket_q;
endmodule

// File: tb/tb_ball_mover.sv
// Self-checking bench for ball_mover: directed test-plan cases plus randomized traffic against a reference model.
module tb_ball_mover;
  localparam int FRAC   = 4;
  localparam int W      = 11 + FRAC;
  localparam int PERIOD = 4;
  localparam int MAXV   = 255;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  ball_mover_if bmif();

  ball_mover #(
    .INIT_X(11'sd100), .INIT_Y(11'sd200), .FRAC(FRAC),
    .MAX_SPEED(11'sd255), .FRICTION_PERIOD(PERIOD)
  ) dut (
    .clk(clk), .reset(reset), .bm(bmif)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: mode 0 idle, 1 moving, 2 pocketed; position in 1/2^FRAC pixel units.
  int m_mode, m_px, m_py, m_vx, m_vy, m_pend, m_lx, m_ly, m_cnt;

  function automatic int clampv(input int v);
    if (v > MAXV)  return MAXV;
    if (v < -MAXV) return -MAXV;
    return v;
  endfunction

  function automatic int wrapw(input int p);
    int m, r;
    m = 1 << W;
    r = (p + m / 2) % m;
    if (r < 0) r += m;
    return r - m / 2;
  endfunction

  function automatic int tz(input int v);
    return (v > 0) ? v - 1 : (v < 0) ? v + 1 : 0;
  endfunction

  task automatic model_step();
    int hx, hy, cx, cy;
    hx = bmif.hitVelX;       hy = bmif.hitVelY;
    cx = bmif.collisionVelX; cy = bmif.collisionVelY;
    if (reset) begin
      m_mode = 0; m_px = 100 * (1 << FRAC); m_py = 200 * (1 << FRAC);
      m_vx = 0; m_vy = 0; m_pend = 0; m_cnt = 0;
    end else if (m_mode != 2 && bmif.pocketed) begin
      m_mode = 2; m_vx = 0; m_vy = 0; m_pend = 0;
    end else if (m_mode == 0) begin
      if (bmif.hitValid && (hx != 0 || hy != 0)) begin
        m_vx = clampv(hx); m_vy = clampv(hy); m_mode = 1; m_cnt = 0;
      end
    end else if (m_mode == 1) begin
      if (bmif.startOfFrame) begin
        if (m_pend) begin m_vx = clampv(m_lx); m_vy = clampv(m_ly); end
        m_pend = 0;
`ifdef BALL_MOVER_FRICTION_EN
        m_cnt = (m_cnt + 1) % PERIOD;
        if (m_cnt == 0) begin m_vx = tz(m_vx); m_vy = tz(m_vy); end
`endif
        m_px = wrapw(m_px + m_vx);
        m_py = wrapw(m_py + m_vy);
        if (m_vx == 0 && m_vy == 0) m_mode = 0;
        else if (bmif.collisionOccurred) begin m_pend = 1; m_lx = cx; m_ly = cy; end
      end else if (bmif.collisionOccurred && !m_pend) begin
        m_pend = 1; m_lx = cx; m_ly = cy;
      end
    end
  endtask

  task automatic compare_all();
    chk("topLeftX", bmif.topLeftX, m_px >>> FRAC);
    chk("topLeftY", bmif.topLeftY, m_py >>> FRAC);
    chk("velX", bmif.velX, m_vx);
    chk("velY", bmif.velY, m_vy);
    chk("moving", int'(bmif.moving), int'(m_mode == 1));
    chk("inPocket", int'(bmif.inPocket), int'(m_mode == 2));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic clr_in();
    bmif.startOfFrame = 1'b0; bmif.hitValid = 1'b0;
    bmif.hitVelX = '0; bmif.hitVelY = '0;
    bmif.collisionOccurred = 1'b0;
    bmif.collisionVelX = '0; bmif.collisionVelY = '0;
    bmif.pocketed = 1'b0;
  endtask

  task automatic do_reset();
    clr_in(); reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic hit(input int x, input int y);
    bmif.hitValid = 1'b1; bmif.hitVelX = 11'(x); bmif.hitVelY = 11'(y);
    tick(); clr_in();
  endtask

  task automatic frame();
    bmif.startOfFrame = 1'b1; tick(); clr_in(); tick();
  endtask

  task automatic coll(input int x, input int y);
    bmif.collisionOccurred = 1'b1;
    bmif.collisionVelX = 11'(x); bmif.collisionVelY = 11'(y);
    tick(); clr_in();
  endtask

  function automatic int rv();
    if ($urandom_range(0, 7) == 0) return 0;
    return int'($urandom_range(0, 1400)) - 700;
  endfunction

  initial begin
    int sx, sy;
    clr_in();
    do_reset(); tick();
    chk("reset_x", bmif.topLeftX, 100);
    chk("reset_y", bmif.topLeftY, 200);
    chk("reset_vx", bmif.velX, 0);
    chk("reset_moving", int'(bmif.moving), 0);
    chk("reset_pocket", int'(bmif.inPocket), 0);

    hit(32, -16);
    chk("hit_moving", int'(bmif.moving), 1);
    chk("hit_vx", bmif.velX, 32);
    chk("hit_vy", bmif.velY, -16);
    frame();
    chk("frame1_x", bmif.topLeftX, 102);
    chk("frame1_y", bmif.topLeftY, 199);

    do_reset(); hit(600, -600);
    chk("clamp_vx", bmif.velX, 255);
    chk("clamp_vy", bmif.velY, -255);

    do_reset(); hit(32, 0); frame();
    coll(-32, 0); coll(50, 50); frame();
    chk("coll_vx", bmif.velX, -32);
    chk("coll_vy", bmif.velY, 0);
    chk("coll_x", bmif.topLeftX, 100);

`ifdef BALL_MOVER_FRICTION_EN
    do_reset(); hit(3, 0);
    for (int f = 1; f <= 12; f++) begin
      frame();
      if (f == 4)  chk("fric_f4", bmif.velX, 2);
      if (f == 8)  chk("fric_f8", bmif.velX, 1);
      if (f == 12) chk("fric_f12", bmif.velX, 0);
    end
    chk("fric_stopped", int'(bmif.moving), 0);
    hit(5, 5);
    chk("fric_rehit", int'(bmif.moving), 1);
`endif

    do_reset(); hit(40, 40); frame();
    sx = bmif.topLeftX; sy = bmif.topLeftY;
    bmif.pocketed = 1'b1; bmif.startOfFrame = 1'b1; bmif.collisionOccurred = 1'b1;
    bmif.collisionVelX = 11'sd100; bmif.collisionVelY = 11'sd100;
    tick(); clr_in();
    chk("pocket_x", bmif.topLeftX, sx);
    chk("pocket_y", bmif.topLeftY, sy);
    chk("pocket_vx", bmif.velX, 0);
    chk("pocket_flag", int'(bmif.inPocket), 1);
    hit(50, 50); frame();
    chk("pocket_hold_vx", bmif.velX, 0);
    chk("pocket_hold_flag", int'(bmif.inPocket), 1);
    chk("pocket_hold_x", bmif.topLeftX, sx);

    do_reset(); hit(80, -128);
    repeat (10) frame();
    chk("mid_moving", int'(bmif.moving), 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("midrst_x", bmif.topLeftX, 100);
    chk("midrst_y", bmif.topLeftY, 200);
    chk("midrst_moving", int'(bmif.moving), 0);

    for (int i = 0; i < 4000; i++) begin
      reset                  = ($urandom_range(0, 299) == 0);
      bmif.pocketed          = ($urandom_range(0, 599) == 0);
      bmif.hitValid          = ($urandom_range(0, 9) == 0);
      bmif.hitVelX           = 11'(rv());
      bmif.hitVelY           = 11'(rv());
      bmif.startOfFrame      = ($urandom_range(0, 5) == 0);
      bmif.collisionOccurred = ($urandom_range(0, 4) == 0);
      bmif.collisionVelX     = 11'(rv());
      bmif.collisionVelY     = 11'(rv());
      tick();
    end
    reset = 1'b0; clr_in();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ball_mover.md
# ball_mover

Per-ball motion engine: owns one ball's fixed-point position and velocity, advances them once per video frame, and applies the velocity override issued by the collision/hit controller. Sits upstream of the hit controller, which reads this block's position and velocity. Sits downstream of the same controller for its collision outputs. One instance per ball (white, red).

## Interface
- INIT_X, 11'sd100: top-left X after reset, pixels
- INIT_Y, 11'sd200: top-left Y after reset, pixels
- FRAC, 4: fractional bits of position; velocity unit is 1/2^FRAC pixel/frame
- MAX_SPEED, 11'sd255: velocity magnitude clamp per axis
- FRICTION_PERIOD, 4: frames between friction decrements
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- startOfFrame  in  1  one-cycle pulse, frame update strobe
- hitValid  in  1  cue strike request, one-cycle pulse
- hitVelX, hitVelY  in  11 signed  cue strike velocity
- collisionOccurred  in  1  collision flag from hit controller
- collisionVelX, collisionVelY  in  11 signed  replacement velocity
- pocketed  in  1  ball entered a hole
- topLeftX, topLeftY  out  11 signed  integer pixel position
- velX, velY  out  11 signed  current velocity
- moving  out  1  high in MOVING
- inPocket  out  1  high in POCKETED

## Operation
- States: IDLE (velocity zero), MOVING, POCKETED.
- IDLE: hitValid loads clamped hitVel into velocity and moves to MOVING on the next cycle. If hitVel is (0,0), the block stays in IDLE. Collisions are ignored.
- MOVING, collision latch: the first collisionOccurred cycle after a startOfFrame captures collisionVelX/Y. Later assertions in the same frame are ignored. A collision on the same cycle as startOfFrame is latched for the following frame.
- MOVING, hitValid: ignored.
- MOVING, at startOfFrame, in this order:
  - If the latch is set, velocity is replaced by the clamped latched value, then the latch clears.
  - Friction applies if enabled (see Configuration).
  - Position advances: pos += sign-extended velocity, with 11+FRAC-bit wraparound arithmetic.
  - If both velocity components are then zero, the state moves to IDLE.
- Position advance uses the post-collision, post-friction velocity.
- pocketed, any non-POCKETED state: goes to POCKETED, velocity is zeroed, latch clears. pocketed has priority over every other event in the same cycle.
- POCKETED: terminal. Position freezes, and all inputs except reset are ignored.
- Clamp: values above +MAX_SPEED become +MAX_SPEED; values below −MAX_SPEED become −MAX_SPEED.
- Outputs:
  - topLeftX/Y = pos >>> FRAC (arithmetic shift).
  - moving = (state==MOVING).
  - inPocket = (state==POCKETED).

## Timing
- All outputs are registered and change only on clk rising edge.
- Reset values:
  - pos = INIT_X/INIT_Y << FRAC, so topLeftX = INIT_X and topLeftY = INIT_Y.
  - velX = velY = 0.
  - State IDLE; moving = 0, inPocket = 0.
  - Latch clear; friction counter = 0.
- Reset mid-motion aborts within one cycle; no frame update occurs on a reset cycle.
- Hit latency: velX/velY and moving are valid 1 cycle after hitValid.
- Frame latency: updated position, velocity and state are valid 1 cycle after startOfFrame.
- pocketed latency: inPocket = 1 and velocity = 0 one cycle after pocketed.

## Configuration
- BALL_MOVER_FRICTION_EN defined:
  - A 0..FRICTION_PERIOD-1 counter increments each MOVING frame and wraps.
  - On wrap, each nonzero velocity component moves 1 toward zero; it never crosses zero.
  - The counter clears on entering MOVING.
  - The ball eventually stops and returns to IDLE.
- Undefined: no counter. Velocity changes only via collision or pocket, and MOVING persists until a zero-velocity collision or pocketed.

## Test plan
- Reset and hit:
  - Reset → topLeft = (100,200), vel = 0, moving = 0.
  - hitValid with (32,−16), FRAC = 4 → next cycle moving = 1.
  - After one startOfFrame → topLeft = (102,199).
- Clamp: hitVel = (600,−600) → vel = (255,−255).
- Collision, one per frame: two collisions in one frame, (−32,0) then (50,50) → after startOfFrame vel = (−32,0) and X decreases by 2.
- Friction (BALL_MOVER_FRICTION_EN, period 4), hit (3,0):
  - vel = 2 after frame 4, 1 after frame 8, 0 after frame 12.
  - Then moving = 0 and hitValid is accepted again.
- Pocket: pocketed asserted together with startOfFrame and collisionOccurred → position unchanged, vel = 0, inPocket = 1. A later hitValid has no effect until reset.
- Reset mid-motion: reset while MOVING at (150,120) → next cycle topLeft = (100,200), IDLE.
